// File: rtl/ex_muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO; 32 shift-add or restoring steps.
// Accept cycle + 32 steps stalled, commit on the edge into DONE; flush aborts, MFHI/MFLO read is combinational.
module ex_muldiv_ctrl #(
  parameter int ITERS = 32,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic        flush,
  input  logic [31:0] instr,
  input  logic [31:0] rdata1,
  input  logic [31:0] rdata2,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hilo_rdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [63:0]        acc;
  logic [31:0]        opb;
  logic               neg_q;
  logic               neg_r;

  logic [5:0] funct;
  logic       special;
  logic       is_mult, is_multu, is_div, is_divu, is_mthi, is_mtlo, is_mfhi, is_mflo;
  logic       is_signed, start, last;
  logic [31:0] a_abs, b_abs;

  assign funct    = instr[5:0];
  assign special  = (instr[31:26] == 6'h00);
  assign is_mfhi  = special && (funct == 6'h10);
  assign is_mthi  = special && (funct == 6'h11);
  assign is_mflo  = special && (funct == 6'h12);
  assign is_mtlo  = special && (funct == 6'h13);
  assign is_mult  = special && (funct == 6'h18);
  assign is_multu = special && (funct == 6'h19);
  assign is_div   = special && (funct == 6'h1A);
  assign is_divu  = special && (funct == 6'h1B);

  assign is_signed = is_mult || is_div;
  assign start = valid && !flush && (state == IDLE) && (is_mult || is_multu || is_div || is_divu);
  assign last  = (cnt == CNT_W'(ITERS - 1));
  assign a_abs = (is_signed && rdata1[31]) ? -rdata1 : rdata1;
  assign b_abs = (is_signed && rdata2[31]) ? -rdata2 : rdata2;

  // Multiply step: conditional add into the upper half, then shift the 65-bit value right.
  logic [32:0] msum;
  logic [63:0] mul_nx;
  assign msum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
  assign mul_nx = {msum, acc[31:1]};

  // Divide step: acc holds {remainder, dividend/quotient}; restore when the trial subtract borrows.
  logic [32:0] dsh;
  logic [33:0] ddiff;
  logic [63:0] div_nx;
  assign dsh    = {acc[63:32], acc[31]};
  assign ddiff  = {1'b0, dsh} - {2'b00, opb};
  assign div_nx = {(ddiff[33] ? dsh[31:0] : ddiff[31:0]), acc[30:0], ~ddiff[33]};

  logic [63:0] prod_fix;
  assign prod_fix = neg_q ? -mul_nx : mul_nx;

  logic unused_bits;
  assign unused_bits = ^{instr[25:6], ddiff[32]};

  always_comb begin
    stall = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE:     stall = start;
        MUL, DIV: stall = !flush;
        default:  stall = 1'b0;
      endcase
    end
  end

  assign hilo_rdata = is_mfhi ? hi : (is_mflo ? lo : 32'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      opb   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= '0;
            neg_q <= is_signed && (rdata1[31] ^ rdata2[31]);
            neg_r <= is_signed && rdata1[31];
            busy  <= 1'b1;
            if (is_mult || is_multu) begin
              state <= MUL;
              acc   <= {32'd0, b_abs};
              opb   <= a_abs;
            end else begin
              state <= DIV;
              acc   <= {32'd0, a_abs};
              opb   <= b_abs;
            end
          end else if (valid && !flush) begin
            if (is_mthi) hi <= rdata1;
            if (is_mtlo) lo <= rdata1;
          end
        end
        MUL, DIV: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            acc <= (state == MUL) ? mul_nx : div_nx;
            cnt <= cnt + 1'b1;
            if (last) begin
              state <= DONE;
              busy  <= 1'b0;
              cnt   <= '0;
              if (state == MUL) begin
                hi <= prod_fix[63:32];
                lo <= prod_fix[31:0];
              end else begin
                lo <= neg_q ? -div_nx[31:0]  : div_nx[31:0];
                hi <= neg_r ? -div_nx[63:32] : div_nx[63:32];
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
